serial_mag_comparator: RTL

- Bit-serial N-bit magnitude comparator. It is the downstream consumer of our 1-bit compare stage.
- It loads two WIDTH-bit operands, walks them MSB-first one bit per clock, and evaluates a 1-bit equal/less/greater per bit.
- It latches the first non-equal bit decision and reports a single eq/lt/gt result with a done pulse.
- It sits in the control-logic path wherever a multi-bit compare is needed but area matters more than latency.

---
 rtl/serial_mag_comparator.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial unsigned magnitude comparator. Two WIDTH-bit operands are
//   captured on an accepted start. They are walked MSB-first, one bit per
//   clock. The first differing bit decides the result. The result is
//   reported as a single eq/lt/gt flag together with a one-cycle done pulse.
//   Latency is fixed at WIDTH+1 cycles from accept to done.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears all state
//   start : compare request, honoured in IDLE and DONE only
//   a_in  : operand A, captured on an accepted start
//   b_in  : operand B, captured on an accepted start
//   busy  : high while bits are being shifted (SHIFT state)
//   done  : one-cycle pulse; eq/lt/gt are valid from this cycle on
//   eq    : registered A == B
//   lt    : registered A <  B (unsigned)
//   gt    : registered A >  B (unsigned)
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             lt_i_q, lt_i_d;
  logic             gt_i_q, gt_i_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  // Current bit pair and the 1-bit compare of that pair
  logic a_bit, b_bit;
  logic bit_lt, bit_gt, bit_ne;

  always_comb begin
    a_bit  = sa_q[WIDTH-1];
    b_bit  = sb_q[WIDTH-1];
    bit_lt = ~a_bit & b_bit;
    bit_gt = a_bit & ~b_bit;
    bit_ne = a_bit ^ b_bit;
  end

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    lt_i_d    = lt_i_q;
    gt_i_d    = gt_i_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;

    case (state_q)
      ST_SHIFT: begin
        // Only the first differing bit counts; later bits are shifted out unused
        if (!decided_q && bit_ne) begin
          decided_d = 1'b1;
          lt_i_d    = bit_lt;
          gt_i_d    = bit_gt;
        end
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last bit: publish using the decision including this bit
          state_d = ST_DONE;
          eq_d    = ~decided_d;
          lt_d    = lt_i_d;
          gt_d    = gt_i_d;
        end
      end
      ST_IDLE, ST_DONE: begin
        // DONE accepts start exactly as IDLE so compares can run back-to-back
        state_d = ST_IDLE;
        if (start) begin
          state_d   = ST_SHIFT;
          sa_d      = a_in;
          sb_d      = b_in;
          cnt_d     = CW'(WIDTH);
          decided_d = 1'b0;
          lt_i_d    = 1'b0;
          gt_i_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      lt_i_q    <= 1'b0;
      gt_i_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      lt_i_q    <= lt_i_d;
      gt_i_q    <= gt_i_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule
